// File: rtl/ucode_sequencer.sv
// Micro-op sequencer: passes single micro-ops through or walks a 2^(ROM_AW-4)-word ROM region per instruction.
// Latency 1 cycle direct / 2 cycles to first ROM micro-op; stalls hold all state. Optional macro UCODE_SEQ_PERF_EN.
module ucode_sequencer #(
    parameter int UOP_W  = 64,
    parameter int ROM_AW = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [UOP_W-1:0]  in_uop,
    input  logic              rom_in_control,
    input  logic [3:0]        rom_control,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [UOP_W-1:0]  rom_data,
    input  logic              rom_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [UOP_W-1:0]  out_uop,
    output logic              out_last,
    output logic              seq_overrun
`ifdef UCODE_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_rom_uops
`endif
);
    localparam int OFF_W = ROM_AW - 4;

    typedef enum logic {IDLE, SEQ} state_e;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [UOP_W-1:0]  out_uop_q, out_uop_d;
    logic              out_last_q, out_last_d;
    logic              seq_overrun_q, seq_overrun_d;
    logic              rom_load;

    logic              slot_free;
    logic              region_end;
    logic              seq_done;
    logic [OFF_W-1:0]  off_inc;

    assign slot_free  = ~out_valid_q | out_ready;
    assign region_end = &rom_addr_q[OFF_W-1:0];
    assign seq_done   = rom_last | region_end;
    // Offset increments inside the selected region only; the entry-point bits never change mid-sequence.
    assign off_inc    = rom_addr_q[OFF_W-1:0] + OFF_W'(1);

    assign in_ready    = (state_q == IDLE) & slot_free;
    assign rom_addr    = rom_addr_q;
    assign out_valid   = out_valid_q;
    assign out_uop     = out_uop_q;
    assign out_last    = out_last_q;
    assign seq_overrun = seq_overrun_q;

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        out_valid_d   = out_valid_q;
        out_uop_d     = out_uop_q;
        out_last_d    = out_last_q;
        seq_overrun_d = 1'b0;
        rom_load      = 1'b0;

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (slot_free) begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    if (rom_in_control) begin
                        rom_addr_d = {rom_control, {OFF_W{1'b0}}};
                        state_d    = SEQ;
                    end else begin
                        out_uop_d   = in_uop;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                    end
                end
            end
        end else begin
            if (slot_free) begin
                rom_load      = 1'b1;
                out_uop_d     = rom_data;
                out_valid_d   = 1'b1;
                out_last_d    = seq_done;
                seq_overrun_d = region_end & ~rom_last;
                if (seq_done) begin
                    state_d = IDLE;
                end else begin
                    rom_addr_d = {rom_addr_q[ROM_AW-1:OFF_W], off_inc};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            rom_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            out_uop_q     <= '0;
            out_last_q    <= 1'b0;
            seq_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            out_valid_q   <= out_valid_d;
            out_uop_q     <= out_uop_d;
            out_last_q    <= out_last_d;
            seq_overrun_q <= seq_overrun_d;
        end
    end

`ifdef UCODE_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (rom_load && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_rom_uops = perf_q;
`else
    logic unused_rom_load;
    assign unused_rom_load = rom_load;
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: directed scenarios plus a randomized run against a queue-based model.
module tb_ucode_sequencer;
    localparam int UOP_W  = 64;
    localparam int ROM_AW = 6;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, rom_in_control, rom_last;
    logic              out_valid, out_ready, out_last, seq_overrun;
    logic [UOP_W-1:0]  in_uop, rom_data, out_uop;
    logic [3:0]        rom_control;
    logic [ROM_AW-1:0] rom_addr;
`ifdef UCODE_SEQ_PERF_EN
    logic [15:0]       perf_rom_uops;
`endif

    logic [UOP_W-1:0]  rom_mem      [0:63];
    logic              rom_last_mem [0:63];

    int errors   = 0;
    int checks   = 0;
    int perf_exp = 0;

    typedef struct packed {
        logic [UOP_W-1:0] uop;
        logic             last;
    } exp_t;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];
    assign rom_last = rom_last_mem[rom_addr];

    ucode_sequencer #(.UOP_W(UOP_W), .ROM_AW(ROM_AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_uop         (in_uop),
        .rom_in_control (rom_in_control),
        .rom_control    (rom_control),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_last       (rom_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_uop        (out_uop),
        .out_last       (out_last),
        .seq_overrun    (seq_overrun)
`ifdef UCODE_SEQ_PERF_EN
        ,
        .perf_rom_uops  (perf_rom_uops)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 64; a++) begin
            rom_mem[a]      = {$urandom, $urandom};
            rom_last_mem[a] = 1'b0;
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; rom_in_control = 1'b0;
        rom_control = 4'd0; in_uop = '0; out_ready = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
        checks++; if (seq_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", seq_overrun); end
        checks++; if (rom_addr !== 6'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (out_uop !== 64'd0) begin errors++; $display("FAIL reset_out_uop got=%h exp=0", out_uop); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        perf_exp = 0;
`ifdef UCODE_SEQ_PERF_EN
        checks++; if (perf_rom_uops !== 16'(perf_exp)) begin errors++; $display("FAIL reset_perf got=%0d exp=%0d", perf_rom_uops, perf_exp); end
`endif
    endtask

    task automatic test_single();
        in_valid = 1'b1; rom_in_control = 1'b0; in_uop = 64'hA5; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_uop !== 64'hA5) begin errors++; $display("FAIL single_out_uop got=%h exp=a5", out_uop); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_out_last got=%0b exp=1", out_last); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
    endtask

    // Walks one ROM region; n_exp micro-ops, the last one flagged, overrun only when the region end forces it.
    task automatic run_rom(input int rc, input int n_exp, input bit ovr_exp, input string nm);
        int base;
        base = rc * 4;
        in_valid = 1'b1; rom_in_control = 1'b1; rom_control = 4'(rc); out_ready = 1'b1;
        step();
        in_valid = 1'b0; rom_in_control = 1'b0;
        checks++; if (rom_addr !== 6'(base)) begin errors++; $display("FAIL %s_entry_addr got=%0d exp=%0d", nm, rom_addr, base); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_entry_in_ready got=%0b exp=0", nm, in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_entry_out_valid got=%0b exp=0", nm, out_valid); end
        for (int k = 0; k < n_exp; k++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d] got=%0b exp=1", nm, k, out_valid); end
            checks++; if (out_uop !== rom_mem[base + k]) begin errors++; $display("FAIL %s_uop[%0d] got=%h exp=%h", nm, k, out_uop, rom_mem[base + k]); end
            checks++; if (out_last !== (k == n_exp - 1)) begin errors++; $display("FAIL %s_last[%0d] got=%0b", nm, k, out_last); end
            checks++; if (seq_overrun !== (ovr_exp && (k == n_exp - 1))) begin errors++; $display("FAIL %s_overrun[%0d] got=%0b", nm, k, seq_overrun); end
            if (k < n_exp - 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_in_ready[%0d] got=%0b exp=0", nm, k, in_ready); end
                checks++; if (rom_addr !== 6'(base + k + 1)) begin errors++; $display("FAIL %s_addr[%0d] got=%0d exp=%0d", nm, k, rom_addr, base + k + 1); end
            end
        end
        perf_exp += n_exp;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_in_ready got=%0b exp=1", nm, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain got=%0b exp=0", nm, out_valid); end
        checks++; if (seq_overrun !== 1'b0) begin errors++; $display("FAIL %s_overrun_pulse got=%0b exp=0", nm, seq_overrun); end
`ifdef UCODE_SEQ_PERF_EN
        checks++; if (perf_rom_uops !== 16'(perf_exp)) begin errors++; $display("FAIL %s_perf got=%0d exp=%0d", nm, perf_rom_uops, perf_exp); end
`endif
    endtask

    task automatic test_rom_seq();
        rom_last_mem[14] = 1'b1;
        run_rom(3, 3, 1'b0, "rom_seq");
    endtask

    task automatic test_overrun();
        run_rom(2, 4, 1'b1, "overrun");
    endtask

    task automatic test_stall();
        rom_last_mem[6] = 1'b1;
        in_valid = 1'b1; rom_in_control = 1'b1; rom_control = 4'd1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; rom_in_control = 1'b0;
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%0b exp=1", c, out_valid); end
            checks++; if (out_uop !== rom_mem[4]) begin errors++; $display("FAIL stall_uop[%0d] got=%h exp=%h", c, out_uop, rom_mem[4]); end
            checks++; if (rom_addr !== 6'd5) begin errors++; $display("FAIL stall_addr[%0d] got=%0d exp=5", c, rom_addr); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", c, in_ready); end
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_uop !== rom_mem[5] || out_last !== 1'b0) begin errors++; $display("FAIL stall_resume1 got=%h/%0b exp=%h/0", out_uop, out_last, rom_mem[5]); end
        step();
        checks++; if (out_uop !== rom_mem[6] || out_last !== 1'b1) begin errors++; $display("FAIL stall_resume2 got=%h/%0b exp=%h/1", out_uop, out_last, rom_mem[6]); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0b exp=0", out_valid); end
        perf_exp += 3;
    endtask

    task automatic test_flush_reset();
        in_valid = 1'b1; rom_in_control = 1'b1; rom_control = 4'd3; out_ready = 1'b1;
        step();
        in_valid = 1'b0; rom_in_control = 1'b0;
        step();
        perf_exp += 1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL flush_out_last got=%0b exp=0", out_last); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
`ifdef UCODE_SEQ_PERF_EN
        checks++; if (perf_rom_uops !== 16'(perf_exp)) begin errors++; $display("FAIL flush_perf got=%0d exp=%0d", perf_rom_uops, perf_exp); end
`endif
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_resume got=%0b exp=0", out_valid); end
        in_valid = 1'b1; in_uop = 64'h77; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_over_handshake got=%0b exp=0", out_valid); end
        in_valid = 1'b1; rom_in_control = 1'b1; rom_control = 4'd2;
        step();
        in_valid = 1'b0; rom_in_control = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        perf_exp = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midseq_reset_valid got=%0b exp=0", out_valid); end
        checks++; if (rom_addr !== 6'd0) begin errors++; $display("FAIL midseq_reset_addr got=%0d exp=0", rom_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midseq_reset_in_ready got=%0b exp=1", in_ready); end
`ifdef UCODE_SEQ_PERF_EN
        checks++; if (perf_rom_uops !== 16'(perf_exp)) begin errors++; $display("FAIL midseq_reset_perf got=%0d exp=0", perf_rom_uops); end
`endif
        in_valid = 1'b1; in_uop = 64'h5A;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_uop !== 64'h5A) begin errors++; $display("FAIL post_reset_accept got=%0b/%h exp=1/5a", out_valid, out_uop); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_random();
        exp_t exp_q[$];
        exp_t e;
        int   pending = 0;
        int   ovr_exp = 0;
        int   ovr_seen = 0;
        bit   slot_free, exp_ready;
        for (int a = 0; a < 64; a++) begin
            rom_mem[a]      = {$urandom, $urandom};
            rom_last_mem[a] = ($urandom_range(0, 2) == 0);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (seq_overrun === 1'b1) ovr_seen++;
            in_valid       = (cyc < 380) && ($urandom_range(0, 1) == 1);
            rom_in_control = $urandom_range(0, 1);
            rom_control    = 4'($urandom_range(0, 15));
            in_uop         = {$urandom, $urandom};
            out_ready      = (cyc >= 380) || ($urandom_range(0, 3) != 0);
            #1;
            slot_free = (out_valid !== 1'b1) || out_ready;
            exp_ready = (pending == 0) && slot_free;
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ready); end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious cyc=%0d got=%h exp=none", cyc, out_uop);
                end else begin
                    e = exp_q.pop_front();
                    if (out_uop !== e.uop || out_last !== e.last) begin
                        errors++; $display("FAIL rand_uop cyc=%0d got=%h/%0b exp=%h/%0b", cyc, out_uop, out_last, e.uop, e.last);
                    end
                end
            end
            if (pending > 0) begin
                if (slot_free) pending--;
            end else if (in_valid && exp_ready) begin
                if (rom_in_control) begin
                    for (int i = 0; i < 4; i++) begin
                        int  a;
                        bit  lst;
                        a   = rom_control * 4 + i;
                        lst = rom_last_mem[a] || (i == 3);
                        e.uop = rom_mem[a]; e.last = lst;
                        exp_q.push_back(e);
                        pending++;
                        if (i == 3 && !rom_last_mem[a]) ovr_exp++;
                        if (lst) break;
                    end
                    perf_exp += pending;
                end else begin
                    e.uop = in_uop; e.last = 1'b1;
                    exp_q.push_back(e);
                end
            end
            step();
        end
        if (seq_overrun === 1'b1) ovr_seen++;
        in_valid = 1'b0;
        checks++; if (exp_q.size() != 0 || pending != 0) begin errors++; $display("FAIL rand_drain left=%0d pending=%0d exp=0", exp_q.size(), pending); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_final_valid got=%0b exp=0", out_valid); end
        checks++; if (ovr_seen != ovr_exp) begin errors++; $display("FAIL rand_overruns got=%0d exp=%0d", ovr_seen, ovr_exp); end
`ifdef UCODE_SEQ_PERF_EN
        checks++; if (perf_rom_uops !== 16'(perf_exp)) begin errors++; $display("FAIL rand_perf got=%0d exp=%0d", perf_rom_uops, perf_exp); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_rom_seq();
        test_overrun();
        test_stall();
        test_flush_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
